serial_divider: RTL and testbench
=================================

Name: serial_divider

Overview:
Sequential restoring divider, the inverse operation of the team's multiplier blocks.
Produces one quotient bit per clock, with a start/busy/done handshake.
Divide-by-zero is detected and flagged.
Used wherever a quotient/remainder pair is needed and area matters more than latency.

Parameters:
DIVIDEND_WID, 32, width of dividend and quotient
DIVISOR_WID, 32, width of divisor and remainder

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
dividend  input  DIVIDEND_WID  numerator, captured on accepted start
divisor  input  DIVISOR_WID  denominator, captured on accepted start
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse; quotient/remainder/div_by_zero valid from this cycle
quotient  output  DIVIDEND_WID  result, held until next accepted start
remainder  output  DIVISOR_WID  result, held until next accepted start
div_by_zero  output  1  set with done when divisor was 0; held with results

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE. busy, done, quotient, remainder and div_by_zero are all 0. Internal registers are cleared.
- Reset has priority over every other event, including mid-division. An in-flight operation is abandoned and done is never raised for it.
- FSM states are IDLE, CALC and FINISH.
- IDLE: when start=1 at edge E0, latch the operands and set busy=1.
  - divisor≠0: load the iteration counter with DIVIDEND_WID and go to CALC.
  - divisor=0: go to FINISH directly.
- IDLE with start=0: no change. Outputs hold their last results.
- CALC, once per edge:
  - partial remainder (DIVISOR_WID+1 bits) = {rem, next dividend MSB};
  - trial = partial − divisor;
  - if trial ≥ 0, rem=trial and quotient bit=1; else rem unchanged and bit=0;
  - counter decrements; after DIVIDEND_WID iterations go to FINISH.
- FINISH (one cycle): register quotient/remainder to the outputs, set done=1 and busy=0, and return to IDLE.
- Latency, normal case: start sampled at E0 → done=1 after edge E0+DIVIDEND_WID+1. That is 33 cycles for the defaults.
- Latency, divide-by-zero: start sampled at E0 → done=1 after edge E0+1, with:
  - quotient = all ones;
  - remainder = dividend truncated or zero-extended to DIVISOR_WID;
  - div_by_zero=1.
- div_by_zero is cleared on the next accepted start.
- start while busy=1 is ignored with no side effect, and operands may change freely.
- start during the done cycle is accepted, because the FSM is already in IDLE. This gives back-to-back operations with a 1-cycle gap of busy=0.
- Arithmetic is unsigned by default. Results satisfy dividend = quotient·divisor + remainder, with remainder < divisor.

Optional Feature:
Macro: SERIAL_DIVIDER_SIGNED_EN.
- Defined: operands are two's complement.
  - Magnitudes are taken at capture; the unsigned core runs unchanged.
  - Quotient is negated if operand signs differ. Remainder takes the dividend's sign (truncation toward zero).
  - Most-negative / −1 wraps: quotient = most-negative, remainder = 0.
  - Divide-by-zero gives quotient = all ones (−1), remainder = dividend.
  - Sign fix-up happens in FINISH, so latency is unchanged.
- Undefined: purely unsigned; no sign logic is synthesised.

Test Plan:
- Reset then start, dividend=100, divisor=7 → after 33 cycles done=1 for exactly 1 cycle, quotient=14, remainder=2, div_by_zero=0. busy=1 for those 33 cycles.
- dividend=32'hFFFFFFFF, divisor=1 → quotient=32'hFFFFFFFF, remainder=0. Also dividend=6, divisor=2 → quotient=3, remainder=0. Also dividend=5, divisor=9 → quotient=0, remainder=5.
- dividend=13, divisor=0 → done after 1 cycle, quotient=32'hFFFFFFFF, remainder=13, div_by_zero=1. A following 16/4 clears the flag and gives quotient=4, remainder=0.
- Divide 16/23; change operands and pulse start at cycle 10 while busy → ignored, result quotient=0, remainder=16. Then start 12/13 in the done cycle → accepted, quotient=0, remainder=12.
- rst=1 at cycle 10 of a 1000/3 division → next cycle busy=0, done=0, outputs 0; no done pulse follows. Restart 1000/3 → quotient=333, remainder=1.
- With SERIAL_DIVIDER_SIGNED_EN:
  - −7/2 → quotient=−3, remainder=−1.
  - 7/−2 → quotient=−3, remainder=1.
  - 32'h80000000/−1 → quotient=32'h80000000, remainder=0.

Source files
------------

// File: rtl/serial_divider.sv
// serial_divider: sequential restoring divider, one quotient bit per clock.
// A start/busy/done handshake wraps the iteration, and a zero divisor is
// detected and flagged instead of iterating.
// Optional build macro: SERIAL_DIVIDER_SIGNED_EN. When it is defined, the
// operands are treated as two's complement. Magnitudes go through the
// unsigned core, and the signs are fixed up on the way out. When it is left
// undefined, the divider is purely unsigned and no sign logic exists.

module serial_divider #(
  parameter int DIVIDEND_WID = 32,
  parameter int DIVISOR_WID  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DIVIDEND_WID-1:0] dividend,
  input  logic [DIVISOR_WID-1:0]  divisor,
  output logic                    busy,
  output logic                    done,
  output logic [DIVIDEND_WID-1:0] quotient,
  output logic [DIVISOR_WID-1:0]  remainder,
  output logic                    div_by_zero
);

  // Counter must be able to hold DIVIDEND_WID itself.
  localparam int CNT_WID = $clog2(DIVIDEND_WID + 1);
  localparam logic [CNT_WID-1:0] CNT_LOAD = CNT_WID'(DIVIDEND_WID);
  // Number of dividend bits that survive into a divide-by-zero remainder.
  localparam int MIN_WID = (DIVISOR_WID < DIVIDEND_WID) ? DIVISOR_WID : DIVIDEND_WID;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  state_t state;
  state_t state_next;

  // Shift register: the dividend shifts out at the top while quotient bits
  // shift in at the bottom. After the last iteration it holds the quotient.
  logic [DIVIDEND_WID-1:0] dvd_reg;
  logic [DIVISOR_WID-1:0]  dvs_reg;
  logic [DIVISOR_WID-1:0]  rem_reg;
  logic [CNT_WID-1:0]      count;
  logic                    zero_div;

  // Operands as seen by the unsigned core.
  logic [DIVIDEND_WID-1:0] dvd_mag;
  logic [DIVISOR_WID-1:0]  dvs_mag;

  // One restoring step.
  logic [DIVISOR_WID:0]    partial;
  logic [DIVISOR_WID-1:0]  trial_diff;
  logic                    trial_ok;
  logic [DIVISOR_WID-1:0]  rem_step;

  // Results as they will be registered in FINISH.
  logic [DIVIDEND_WID-1:0] q_fin;
  logic [DIVISOR_WID-1:0]  r_fin;
  logic [DIVISOR_WID-1:0]  r_dz;

  logic                    divisor_zero;

`ifdef SERIAL_DIVIDER_SIGNED_EN
  logic dvd_neg_in;
  logic dvs_neg_in;
  logic q_neg;
  logic r_neg;

  assign dvd_neg_in = dividend[DIVIDEND_WID-1];
  assign dvs_neg_in = divisor[DIVISOR_WID-1];

  // The most-negative value has the same bit pattern as its magnitude,
  // so that case is correct as an unsigned magnitude too.
  assign dvd_mag = dvd_neg_in ? (-dividend) : dividend;
  assign dvs_mag = dvs_neg_in ? (-divisor) : divisor;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  assign divisor_zero = (divisor == '0);
  assign busy         = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A zero divisor skips iteration entirely.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = divisor_zero ? FINISH : CALC;
        end
      end
      CALC: begin
        if (count == CNT_WID'(1)) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One restoring step. When the trial fails, the remainder keeps the
  // partial value, which already has the next dividend bit shifted in.
  always_comb begin
    partial    = {rem_reg, dvd_reg[DIVIDEND_WID-1]};
    trial_ok   = (partial >= {1'b0, dvs_reg});
    trial_diff = partial[DIVISOR_WID-1:0] - dvs_reg;
    rem_step   = trial_ok ? trial_diff : partial[DIVISOR_WID-1:0];
  end

  // Final quotient/remainder, including the divide-by-zero substitution and
  // (in signed builds) sign restoration.
  always_comb begin
    r_dz = '0;
    for (int i = 0; i < MIN_WID; i++) begin
      r_dz[i] = dvd_reg[i];
    end
    q_fin = dvd_reg;
    r_fin = rem_reg;
    if (zero_div) begin
      q_fin = '1;
      r_fin = r_dz;
    end
`ifdef SERIAL_DIVIDER_SIGNED_EN
    if (!zero_div && q_neg) begin
      q_fin = -dvd_reg;
    end
    if (r_neg) begin
      r_fin = -r_fin;
    end
`endif
  end

  // Datapath: operand capture, iteration and result registration.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      rem_reg     <= '0;
      count       <= '0;
      zero_div    <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SERIAL_DIVIDER_SIGNED_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_reg     <= dvd_mag;
            dvs_reg     <= dvs_mag;
            rem_reg     <= '0;
            count       <= CNT_LOAD;
            zero_div    <= divisor_zero;
            div_by_zero <= 1'b0;
`ifdef SERIAL_DIVIDER_SIGNED_EN
            q_neg       <= dvd_neg_in ^ dvs_neg_in;
            r_neg       <= dvd_neg_in;
`endif
          end
        end
        CALC: begin
          dvd_reg <= {dvd_reg[DIVIDEND_WID-2:0], trial_ok};
          rem_reg <= rem_step;
          count   <= count - CNT_WID'(1);
        end
        FINISH: begin
          quotient    <= q_fin;
          remainder   <= r_fin;
          div_by_zero <= zero_div;
          done        <= 1'b1;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_divider.sv
// tb_serial_divider: directed scoreboard bench for serial_divider.
// Expected results are computed here and queued when a division is started,
// then popped and compared when done pulses.

module tb_serial_divider;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];

  int compared;
  int mismatched;

  serial_divider #(
    .DIVIDEND_WID(W),
    .DIVISOR_WID (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls far beyond the expected run length.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain language-level division.
  task automatic modelDivide(input logic [W-1:0] a, input logic [W-1:0] b, output exp_t e);
    e.dz = (b == '0);
`ifdef SERIAL_DIVIDER_SIGNED_EN
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
      e.q = a;
      e.r = '0;
    end else begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end
`else
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
`endif
  endtask

  // Called at a negedge: drives start for one cycle and queues the result.
  // Returns at the negedge just after the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    modelDivide(a, b, e);
    sb.push_back(e);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start = 1'b0;
    checkValue("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  // Waits for done (bounded), checks latency, busy length and the result.
  task automatic checkOutput(input string tag, input int exp_lat);
    int   k;
    int   busy_n;
    exp_t e;
    k      = 0;
    busy_n = 0;
    while (done !== 1'b1 && k < 100) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      k++;
    end
    checkValue({tag, "_latency"}, k, exp_lat);
    checkValue({tag, "_busy_cycles"}, busy_n, exp_lat);
    checkValue({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
    end else begin
      e.q  = 'x;
      e.r  = 'x;
      e.dz = 1'bx;
    end
    checkValue({tag, "_quotient"}, quotient, e.q);
    checkValue({tag, "_remainder"}, remainder, e.r);
    checkValue({tag, "_div_by_zero"}, {31'b0, div_by_zero}, {31'b0, e.dz});
  endtask

  task automatic checkDonePulseEnds(input string tag);
    @(negedge clk);
    checkValue({tag, "_done_one_cycle"}, {31'b0, done}, 32'd0);
  endtask

  // Directed sequence.
  initial begin
    int seen;
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    start      = 1'b0;
    dividend   = '0;
    divisor    = '0;
    repeat (3) @(negedge clk);
    checkValue("reset_busy", {31'b0, busy}, 32'd0);
    checkValue("reset_done", {31'b0, done}, 32'd0);
    checkValue("reset_quotient", quotient, 32'd0);
    checkValue("reset_remainder", remainder, 32'd0);
    checkValue("reset_dz", {31'b0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic divisions");
    applyStimulus(32'd100, 32'd7);
    checkOutput("d100_7", 33);
    checkDonePulseEnds("d100_7");

    applyStimulus(32'hFFFF_FFFF, 32'd1);
    checkOutput("dmax_1", 33);
    applyStimulus(32'd6, 32'd2);
    checkOutput("d6_2", 33);
    applyStimulus(32'd5, 32'd9);
    checkOutput("d5_9", 33);
    checkDonePulseEnds("d5_9");

    $display("[TB] divide by zero");
    applyStimulus(32'd13, 32'd0);
    checkOutput("d13_0", 1);
    checkDonePulseEnds("d13_0");
    applyStimulus(32'd16, 32'd4);
    checkValue("dz_cleared_on_start", {31'b0, div_by_zero}, 32'd0);
    checkOutput("d16_4", 33);
    checkDonePulseEnds("d16_4");

    $display("[TB] start while busy, then back-to-back");
    applyStimulus(32'd16, 32'd23);
    repeat (9) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd999;
    divisor  = 32'd5;
    @(negedge clk);
    start = 1'b0;
    checkOutput("d16_23", 23);
    applyStimulus(32'd12, 32'd13);
    checkOutput("d12_13", 33);
    checkDonePulseEnds("d12_13");

    $display("[TB] reset mid-division");
    applyStimulus(32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_front());
    checkValue("midrst_busy", {31'b0, busy}, 32'd0);
    checkValue("midrst_done", {31'b0, done}, 32'd0);
    checkValue("midrst_quotient", quotient, 32'd0);
    checkValue("midrst_remainder", remainder, 32'd0);
    checkValue("midrst_dz", {31'b0, div_by_zero}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    checkValue("midrst_no_done", seen, 32'd0);
    applyStimulus(32'd1000, 32'd3);
    checkOutput("d1000_3", 33);

`ifdef SERIAL_DIVIDER_SIGNED_EN
    $display("[TB] signed divisions");
    applyStimulus(-32'sd7, 32'sd2);
    checkOutput("s_m7_2", 33);
    checkValue("s_m7_2_q_const", quotient, -32'sd3);
    checkValue("s_m7_2_r_const", remainder, -32'sd1);
    applyStimulus(32'sd7, -32'sd2);
    checkOutput("s_7_m2", 33);
    checkValue("s_7_m2_q_const", quotient, -32'sd3);
    checkValue("s_7_m2_r_const", remainder, 32'd1);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("s_min_m1", 33);
    checkValue("s_min_m1_q_const", quotient, 32'h8000_0000);
    checkValue("s_min_m1_r_const", remainder, 32'd0);
    applyStimulus(-32'sd13, 32'd0);
    checkOutput("s_m13_0", 1);
`endif

    checkValue("scoreboard_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
